// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through reads,
// programmable almost-full/almost-empty thresholds, fill count and sticky error flags.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wrreq,
    input  logic                  rdreq,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rdAccept;
    logic                  wrAccept;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A pop at full frees a slot in the same edge, so a simultaneous push is taken.
    assign rdAccept = rdreq && !empty;
    assign wrAccept = wrreq && (!full || rdAccept);

    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        data_d      = data_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wrAccept) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (rdAccept) begin
            rdPtr_d = rdPtr_q + 1'b1;
            data_d  = mem[rdPtr_q];
        end

        if (wrAccept && !rdAccept) begin
            count_d = count_q + 1'b1;
        end else if (rdAccept && !wrAccept) begin
            count_d = count_q - 1'b1;
        end

        // A fresh error in the same cycle as a clear must still be recorded.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wrreq && full && !rdreq) begin
            overflow_d = 1'b1;
        end
        if (rdreq && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            data_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            data_q      <= data_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && wrAccept) begin
            mem[wrPtr_q] <= data_in;
        end
    end

    // In FWFT mode the head word is shown directly; data_q keeps the last popped word for when empty.
    generate
        if (FWFT != 0) begin : gFwft
            assign data_out = empty ? data_q : mem[rdPtr_q];
        end else begin : gStd
            assign data_out = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param: one standard-mode and one
// FWFT-mode instance share the stimulus; each section checks the relevant one.
module tb_sync_fifo_param;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       wrreq;
    logic       rdreq;
    logic       clr_err;

    logic [7:0] sDataOut, fDataOut;
    logic       sFull, sEmpty, sAf, sAe, sOvf, sUnf;
    logic       fFull, fEmpty, fAf, fAe, fOvf, fUnf;
    logic [4:0] sCount, fCount;

    int nCompared;
    int nMismatched;

    sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) uStd (
        .clk(clk), .rst(rst), .data_in(data_in), .wrreq(wrreq), .rdreq(rdreq), .clr_err(clr_err),
        .data_out(sDataOut), .full(sFull), .empty(sEmpty), .almost_full(sAf), .almost_empty(sAe),
        .count(sCount), .overflow(sOvf), .underflow(sUnf)
    );

    sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)) uFwft (
        .clk(clk), .rst(rst), .data_in(data_in), .wrreq(wrreq), .rdreq(rdreq), .clr_err(clr_err),
        .data_out(fDataOut), .full(fFull), .empty(fEmpty), .almost_full(fAf), .almost_empty(fAe),
        .count(fCount), .overflow(fOvf), .underflow(fUnf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of requests, then return just after the sampling edge.
    task automatic applyStimulus(input logic w, input logic r, input logic [7:0] d);
        wrreq   = w;
        rdreq   = r;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'd0);
        rst = 1'b1;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst     = 1'b0;
        wrreq   = 1'b0;
        rdreq   = 1'b0;
        clr_err = 1'b0;
        data_in = '0;

        doReset();
        checkOutput("rst_count", 32'(sCount), 0);
        checkOutput("rst_empty", 32'(sEmpty), 1);
        checkOutput("rst_ae", 32'(sAe), 1);
        checkOutput("rst_full", 32'(sFull), 0);
        checkOutput("rst_af", 32'(sAf), 0);
        checkOutput("rst_ovf", 32'(sOvf), 0);
        checkOutput("rst_unf", 32'(sUnf), 0);
        checkOutput("rst_dout", 32'(sDataOut), 0);

        // Fill with 1..16, flags move on the same edge as count.
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(i));
            checkOutput("fill_count", 32'(sCount), 32'(i));
            checkOutput("fill_af", 32'(sAf), (i >= 14) ? 32'd1 : 32'd0);
            checkOutput("fill_full", 32'(sFull), (i == 16) ? 32'd1 : 32'd0);
            checkOutput("fill_ae", 32'(sAe), (i <= 2) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 8'd99);
        checkOutput("ovf_set", 32'(sOvf), 1);
        checkOutput("ovf_count", 32'(sCount), 16);

        // Standard-mode drain: each word is on data_out just after its pop edge.
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd0);
            checkOutput("drain_data", 32'(sDataOut), 32'(i));
            checkOutput("drain_count", 32'(sCount), 32'(16 - i));
            checkOutput("drain_ae", 32'(sAe), (16 - i <= 2) ? 32'd1 : 32'd0);
            checkOutput("drain_empty", 32'(sEmpty), (i == 16) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 8'd0);
        checkOutput("unf_set", 32'(sUnf), 1);
        checkOutput("unf_hold", 32'(sDataOut), 16);
        checkOutput("unf_ovf_sticky", 32'(sOvf), 1);

        clr_err = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'd0);
        clr_err = 1'b0;
        checkOutput("clr_ovf", 32'(sOvf), 0);
        checkOutput("clr_unf", 32'(sUnf), 0);

        // Steady state at count 5 with simultaneous push/pop across the wrap.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(50 + i));
        checkOutput("five_count", 32'(sCount), 5);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 1'b1, 8'(100 + k));
            checkOutput("rw_data", 32'(sDataOut), (k < 5) ? 32'(50 + k) : 32'(100 + k - 5));
            checkOutput("rw_count", 32'(sCount), 5);
            checkOutput("rw_flags", {28'd0, sFull, sEmpty, sOvf, sUnf}, 0);
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 8'd0);
            checkOutput("rw_tail", 32'(sDataOut), 32'(115 + k));
        end
        checkOutput("rw_empty", 32'(sEmpty), 1);

        // Simultaneous push/pop while full.
        doReset();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(200 + i));
        applyStimulus(1'b1, 1'b1, 8'd77);
        checkOutput("fullrw_full", 32'(sFull), 1);
        checkOutput("fullrw_ovf", 32'(sOvf), 0);
        checkOutput("fullrw_data", 32'(sDataOut), 200);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd0);
            checkOutput("fullrw_drain", 32'(sDataOut), (i == 16) ? 32'd77 : 32'(200 + i));
        end
        checkOutput("fullrw_empty", 32'(sEmpty), 1);

        // clr_err at count 7 leaves the count alone.
        doReset();
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 8'd0);
        checkOutput("c7_count", 32'(sCount), 7);
        checkOutput("c7_ovf", 32'(sOvf), 1);
        clr_err = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'd0);
        clr_err = 1'b0;
        checkOutput("c7_clr_ovf", 32'(sOvf), 0);
        checkOutput("c7_clr_count", 32'(sCount), 7);

        // Reset with a write pending must win over everything.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8'(30 + i));
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 8'd0);
        checkOutput("r7_count", 32'(sCount), 7);
        checkOutput("r7_ovf", 32'(sOvf), 1);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'd55);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'd0);
        checkOutput("r7_rst_count", 32'(sCount), 0);
        checkOutput("r7_rst_empty", 32'(sEmpty), 1);
        checkOutput("r7_rst_dout", 32'(sDataOut), 0);
        checkOutput("r7_rst_ovf", 32'(sOvf), 0);

        // Error on the same edge as a clear stays set.
        clr_err = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'd0);
        clr_err = 1'b0;
        checkOutput("clr_vs_unf", 32'(sUnf), 1);

        // Write plus read on empty: write taken, read rejected.
        applyStimulus(1'b1, 1'b1, 8'd66);
        checkOutput("emptyrw_count", 32'(sCount), 1);
        checkOutput("emptyrw_dout", 32'(sDataOut), 0);

        // FWFT instance.
        doReset();
        checkOutput("fw_rst_dout", 32'(fDataOut), 0);
        applyStimulus(1'b1, 1'b0, 8'hA5);
        applyStimulus(1'b0, 1'b0, 8'd0);
        checkOutput("fw_empty", 32'(fEmpty), 0);
        checkOutput("fw_head", 32'(fDataOut), 32'hA5);
        applyStimulus(1'b0, 1'b1, 8'd0);
        checkOutput("fw_pop_empty", 32'(fEmpty), 1);
        checkOutput("fw_pop_hold", 32'(fDataOut), 32'hA5);
        applyStimulus(1'b1, 1'b0, 8'hB6);
        applyStimulus(1'b1, 1'b0, 8'hC7);
        checkOutput("fw_head2", 32'(fDataOut), 32'hB6);
        applyStimulus(1'b0, 1'b1, 8'd0);
        checkOutput("fw_head3", 32'(fDataOut), 32'hC7);
        checkOutput("fw_count", 32'(fCount), 1);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
